rp_acq_ch: RTL
==============

RP_ACQ_CH -- requirements
Module: rp_acq_ch

Interface
REQ-001 SHALL have parameter RSZ, default 14, giving buffer address width (2^RSZ samples).
REQ-002 SHALL have port adc_clk_i  in  1  the only clock; all logic on its rising edge.
REQ-003 SHALL have port adc_rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port adc_dat_i  in  14  ADC sample, signed two's complement.
REQ-005 SHALL have port trig_sw_i  in  1  software trigger pulse.
REQ-006 SHALL have port trig_ext_i  in  1  external trigger level, pre-synchronized.
REQ-007 SHALL have port trig_src_i  in  3  source: 0 none, 1 sw, 2 level rising, 3 level falling, 4 ext rising, 5 ext falling, 6-7 none.
REQ-008 SHALL have port set_arm_i  in  1  arm pulse; set_rst_i  in  1  abort pulse.
REQ-009 SHALL have port set_dec_sh_i  in  5  decimation exponent; factor = 2^min(sh,16).
REQ-010 SHALL have port set_tresh_i  in  14  signed level threshold; set_hyst_i  in  14  unsigned hysteresis.
REQ-011 SHALL have port set_dly_i  in  32  post-trigger decimated samples to write.
REQ-012 SHALL have port buf_addr_i  in  RSZ  readback address; buf_rdata_o  out  14  readback data.
REQ-013 SHALL have ports buf_wpnt_o  out  RSZ  write pointer; trig_pnt_o  out  RSZ  write pointer latched at trigger.
REQ-014 SHALL have ports trig_o  out  1  one-cycle accepted-trigger pulse; state_o  out  2  FSM state.

Function
REQ-015 SHALL register adc_dat_i once; one decimated sample SHALL be produced every 2^sh cycles, counter restarting on arm.
REQ-016 SHALL, for sh=0, write the sample presented at edge n into the buffer at edge n+2.
REQ-017 SHALL implement states IDLE=0, ARMED=1, TRIG=2, DONE=3 on state_o.
REQ-018 SHALL write decimated samples only in ARMED and TRIG, at buf_wpnt_o, then increment it modulo 2^RSZ.
REQ-019 SHALL, on set_arm_i in any state, clear buf_wpnt_o and decimation counter and enter ARMED.
REQ-020 SHALL give priority set_rst_i > set_arm_i > trigger; set_rst_i enters IDLE, pointers held.
REQ-021 SHALL accept a trigger only in ARMED; triggers in other states SHALL be ignored with no trig_o.
REQ-022 SHALL, on accepted trigger: pulse trig_o, latch trig_pnt_o = address of the next sample to be written, load delay counter with set_dly_i, enter TRIG.
REQ-023 SHALL decrement the delay counter per write in TRIG and enter DONE on the cycle the counter reaches 0; set_dly_i=0 SHALL enter DONE next cycle with no further writes.
REQ-024 SHALL detect level rising when a decimated sample >= set_tresh_i after a prior sample < set_tresh_i - set_hyst_i (falling mirrored, + set_hyst_i); compare in 16-bit signed, no saturation wrap.
REQ-025 SHALL detect ext edges on trig_ext_i registered once; trig_sw_i SHALL act in the cycle asserted.
REQ-026 SHALL return buf_rdata_o one cycle after buf_addr_i; same-address simultaneous write SHALL return old data.
REQ-027 SHALL hold DONE until set_arm_i or set_rst_i.

Reset
REQ-028 SHALL, while adc_rstn_i low, force state IDLE, buf_wpnt_o=0, trig_pnt_o=0, trig_o=0, buf_rdata_o=0, counters and hysteresis flags 0; buffer contents undefined.
REQ-029 SHALL abandon capture on reset mid-operation; first edge after release SHALL remain IDLE.

Configuration
REQ-030 SHALL, with ACQ_AVG_EN defined, output the mean of each 2^sh input block (19+sh-bit accumulator, arithmetic right shift by sh); without it, the last sample of each block (plain subsampling), same timing.

Verification
REQ-031 SHALL cover: sh=0, ramp input, arm, sw trigger at wpnt=100, set_dly_i=50 -> trig_pnt_o=101, DONE with buf_wpnt_o=151, buffer[k]=ramp values.
REQ-032 SHALL cover: src=2, tresh=1000, hyst=100, input 950->1050 -> no trigger; 850->1050 -> trig_o on crossing sample.
REQ-033 SHALL cover: sh=2, ACQ_AVG_EN, input 0,4,8,12 repeating -> stored 6; without macro -> stored 12.
REQ-034 SHALL cover: wrap with RSZ=4, 40 samples armed -> buf_wpnt_o=8, oldest overwritten.
REQ-035 SHALL cover: set_arm_i and trig_sw_i same cycle -> ARMED, no trig_o; adc_rstn_i low during TRIG -> IDLE, outputs 0.

Source files
------------

// File: rtl/rp_acq_ch.sv
`default_nettype none
// ============================================================================
// Module   : rp_acq_ch
// Function : ADC acquisition channel - decimation, trigger FSM, circular buffer.
//            Define ACQ_AVG_EN to average each decimation block instead of
//            subsampling it.
// Revision : 1.0 - initial release
// ============================================================================
module rp_acq_ch #(
   parameter int RSZ = 14
)(
   input  logic            adc_clk_i,
   input  logic            adc_rstn_i,
   input  logic [13:0]     adc_dat_i,
   input  logic            trig_sw_i,
   input  logic            trig_ext_i,
   input  logic [2:0]      trig_src_i,
   input  logic            set_arm_i,
   input  logic            set_rst_i,
   input  logic [4:0]      set_dec_sh_i,
   input  logic [13:0]     set_tresh_i,
   input  logic [13:0]     set_hyst_i,
   input  logic [31:0]     set_dly_i,
   input  logic [RSZ-1:0]  buf_addr_i,
   output logic [13:0]     buf_rdata_o,
   output logic [RSZ-1:0]  buf_wpnt_o,
   output logic [RSZ-1:0]  trig_pnt_o,
   output logic            trig_o,
   output logic [1:0]      state_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_TRIG  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [13:0]      r_adc_dat;
   logic [15:0]      r_dec_cnt;
   logic             r_dec_vld;
   logic [13:0]      r_dec_dat;
   logic [13:0]      w_dec_nxt;
   logic [4:0]       w_sh;
   logic [15:0]      w_mask;
   logic             w_last;
   logic [RSZ-1:0]   r_wpnt;
   logic [RSZ-1:0]   r_tpnt;
   logic [31:0]      r_dly_cnt;
   logic             r_trig;
   logic [13:0]      r_rdata;
   logic             r_ext, r_ext_d;
   logic             r_rise_arm, r_fall_arm;
   logic             w_lvl_rise, w_lvl_fall;
   logic             w_trig, w_accept, w_wr;
   logic signed [15:0] w_smp, w_tr, w_lo, w_hi;
   logic [13:0]      r_buf [0:(2**RSZ)-1];

   assign w_sh   = (set_dec_sh_i > 5'd16) ? 5'd16 : set_dec_sh_i;
   assign w_mask = 16'((32'd1 << w_sh) - 32'd1);
   assign w_last = (r_dec_cnt >= w_mask);

`ifdef ACQ_AVG_EN
   logic signed [34:0] r_acc;
   logic signed [34:0] w_sum;

   assign w_sum     = r_acc + {{21{r_adc_dat[13]}}, r_adc_dat};
   assign w_dec_nxt = 14'(w_sum >>> w_sh);

   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i)
         r_acc <= '0;
      else if (set_arm_i || w_last)
         r_acc <= '0;
      else
         r_acc <= w_sum;
   end
`else
   assign w_dec_nxt = r_adc_dat;
`endif

   // Block counter restarts on arm so the first block begins with the sample
   // captured on the arming edge.
   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         r_adc_dat <= '0;
         r_dec_cnt <= '0;
         r_dec_vld <= 1'b0;
         r_dec_dat <= '0;
      end else begin
         r_adc_dat <= adc_dat_i;
         if (set_arm_i) begin
            r_dec_cnt <= '0;
            r_dec_vld <= 1'b0;
         end else if (w_last) begin
            r_dec_cnt <= '0;
            r_dec_vld <= 1'b1;
            r_dec_dat <= w_dec_nxt;
         end else begin
            r_dec_cnt <= r_dec_cnt + 16'd1;
            r_dec_vld <= 1'b0;
         end
      end
   end

   assign w_smp = {{2{r_dec_dat[13]}}, r_dec_dat};
   assign w_tr  = {{2{set_tresh_i[13]}}, set_tresh_i};
   assign w_lo  = w_tr - $signed({2'b00, set_hyst_i});
   assign w_hi  = w_tr + $signed({2'b00, set_hyst_i});

   assign w_lvl_rise = r_dec_vld && r_rise_arm && (w_smp >= w_tr);
   assign w_lvl_fall = r_dec_vld && r_fall_arm && (w_smp <= w_tr);

   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         r_rise_arm <= 1'b0;
         r_fall_arm <= 1'b0;
         r_ext      <= 1'b0;
         r_ext_d    <= 1'b0;
      end else begin
         r_ext   <= trig_ext_i;
         r_ext_d <= r_ext;
         if (set_arm_i) begin
            r_rise_arm <= 1'b0;
            r_fall_arm <= 1'b0;
         end else if (r_dec_vld) begin
            if (w_smp < w_lo)
               r_rise_arm <= 1'b1;
            else if (w_smp >= w_tr)
               r_rise_arm <= 1'b0;
            if (w_smp > w_hi)
               r_fall_arm <= 1'b1;
            else if (w_smp <= w_tr)
               r_fall_arm <= 1'b0;
         end
      end
   end

   always_comb begin
      w_trig = 1'b0;
      case (trig_src_i)
         3'd1:    w_trig = trig_sw_i;
         3'd2:    w_trig = w_lvl_rise;
         3'd3:    w_trig = w_lvl_fall;
         3'd4:    w_trig = r_ext & ~r_ext_d;
         3'd5:    w_trig = ~r_ext & r_ext_d;
         default: w_trig = 1'b0;
      endcase
   end

   // A zero delay count in TRIG means the post-trigger window is exhausted.
   assign w_wr = r_dec_vld && !set_rst_i && !set_arm_i &&
                 ((r_state == ST_ARMED) ||
                  ((r_state == ST_TRIG) && (r_dly_cnt != 32'd0)));

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      if (set_rst_i) begin
         w_state_nxt = ST_IDLE;
      end else if (set_arm_i) begin
         w_state_nxt = ST_ARMED;
      end else begin
         case (r_state)
            ST_ARMED: begin
               if (w_trig) begin
                  w_accept    = 1'b1;
                  w_state_nxt = ST_TRIG;
               end
            end
            ST_TRIG: begin
               if (r_dly_cnt == 32'd0)
                  w_state_nxt = ST_DONE;
               else if (w_wr && (r_dly_cnt == 32'd1))
                  w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         r_state   <= ST_IDLE;
         r_wpnt    <= '0;
         r_tpnt    <= '0;
         r_dly_cnt <= '0;
         r_trig    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_trig  <= w_accept;
         if (set_arm_i)
            r_wpnt <= '0;
         else if (w_wr)
            r_wpnt <= r_wpnt + RSZ'(1);
         if (w_accept) begin
            r_tpnt    <= w_wr ? (r_wpnt + RSZ'(1)) : r_wpnt;
            r_dly_cnt <= set_dly_i;
         end else if (w_wr && (r_state == ST_TRIG)) begin
            r_dly_cnt <= r_dly_cnt - 32'd1;
         end
      end
   end

   always_ff @(posedge adc_clk_i) begin
      if (w_wr)
         r_buf[r_wpnt] <= r_dec_dat;
   end

   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i)
         r_rdata <= '0;
      else
         r_rdata <= r_buf[buf_addr_i];
   end

   assign buf_rdata_o = r_rdata;
   assign buf_wpnt_o  = r_wpnt;
   assign trig_pnt_o  = r_tpnt;
   assign trig_o      = r_trig;
   assign state_o     = r_state;

endmodule
`default_nettype wire
